// File: rtl/if_stage_unit.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the fetch PC, presents it to instruction memory, captures the fetched
// word into IF/ID, and tracks hazard stalls and branch flushes with
// saturating counters.
module if_stage_unit #(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int unsigned         CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Hazard_detected_signal,
    input  logic              Br_taken,
    input  logic [ADDR_W-1:0] Br_addr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] IF_ID_PC,
    output logic [31:0]       IF_ID_Instruction,
    output logic              IF_ID_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned INSTR_W = 32;

    // Per-edge operating mode; redirect outranks freeze, freeze outranks advance.
    localparam logic [1:0] MODE_ADVANCE  = 2'd0;
    localparam logic [1:0] MODE_FREEZE   = 2'd1;
    localparam logic [1:0] MODE_REDIRECT = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

    logic [1:0]         mode_c;

    logic [ADDR_W-1:0]  pc_q,        pc_d;
    logic [ADDR_W-1:0]  if_id_pc_q,  if_id_pc_d;
    logic [INSTR_W-1:0] if_id_ins_q, if_id_ins_d;
    logic               if_id_vld_q, if_id_vld_d;
    logic [CNT_W-1:0]   stall_q,     stall_d;
    logic [CNT_W-1:0]   flush_q,     flush_d;

    logic [ADDR_W-1:0]  pc_plus4_c;
    logic [ADDR_W-1:0]  br_target_c;

    // Sequential PC increment wraps naturally; branch target is word-aligned.
    assign pc_plus4_c  = pc_q + PC_STEP;
    assign br_target_c = {Br_addr[ADDR_W-1:2], 2'b00};

    // Mode selection in priority order.
    always_comb begin
        mode_c = MODE_ADVANCE;
        if (Br_taken) begin
            mode_c = MODE_REDIRECT;
        end else if (Hazard_detected_signal) begin
            mode_c = MODE_FREEZE;
        end
    end

    // Next-state computation for PC, IF/ID register and counters.
    always_comb begin
        pc_d        = pc_q;
        if_id_pc_d  = if_id_pc_q;
        if_id_ins_d = if_id_ins_q;
        if_id_vld_d = if_id_vld_q;
        stall_d     = stall_q;
        flush_d     = flush_q;

        case (mode_c)
            MODE_REDIRECT: begin
                pc_d        = br_target_c;
                if_id_pc_d  = '0;
                if_id_ins_d = '0;
                if_id_vld_d = 1'b0;
                if (flush_q != CNT_MAX) begin
                    flush_d = flush_q + CNT_W'(1);
                end
            end
            MODE_FREEZE: begin
                // Everything holds, even when IF/ID carries a bubble.
                if (stall_q != CNT_MAX) begin
                    stall_d = stall_q + CNT_W'(1);
                end
            end
            default: begin
                pc_d        = pc_plus4_c;
                if_id_pc_d  = pc_plus4_c;
                if_id_ins_d = imem_rdata;
                if_id_vld_d = 1'b1;
            end
        endcase
    end

    // State register with synchronous reset overriding all other inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            if_id_pc_q  <= '0;
            if_id_ins_q <= '0;
            if_id_vld_q <= 1'b0;
            stall_q     <= '0;
            flush_q     <= '0;
        end else begin
            pc_q        <= pc_d;
            if_id_pc_q  <= if_id_pc_d;
            if_id_ins_q <= if_id_ins_d;
            if_id_vld_q <= if_id_vld_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
        end
    end

    // Output mapping; instruction address follows the PC register directly.
    assign imem_addr         = pc_q;
    assign PC                = pc_q;
    assign IF_ID_PC          = if_id_pc_q;
    assign IF_ID_Instruction = if_id_ins_q;
    assign IF_ID_valid       = if_id_vld_q;
    assign stall_cnt         = stall_q;
    assign flush_cnt         = flush_q;

endmodule

// File: tb/tb_if_stage_unit.sv
// Directed bench for if_stage_unit: reset, free-run, freeze, redirect,
// PC wrap, counter saturation and reset during a redirect.
`timescale 1ns/1ps
module tb_if_stage_unit;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              hazard;
    logic              br_taken;
    logic [ADDR_W-1:0] br_addr;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] if_id_pc;
    logic [31:0]       if_id_ins;
    logic              if_id_valid;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    if_stage_unit #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(32'h0000_0000),
        .CNT_W   (CNT_W)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .Hazard_detected_signal(hazard),
        .Br_taken              (br_taken),
        .Br_addr               (br_addr),
        .imem_addr             (imem_addr),
        .imem_rdata            (imem_rdata),
        .PC                    (pc),
        .IF_ID_PC              (if_id_pc),
        .IF_ID_Instruction     (if_id_ins),
        .IF_ID_valid           (if_id_valid),
        .stall_cnt             (stall_cnt),
        .flush_cnt             (flush_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory: word at byte address k holds 0x1000_0000 + k.
    assign imem_rdata = 32'h1000_0000 + imem_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] ipc,
                            input logic vld, input logic [31:0] p);
        chk({tag, ".ins"},   if_id_ins, ins);
        chk({tag, ".ifpc"},  if_id_pc, ipc);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(vld));
        chk({tag, ".pc"},    pc, p);
        chk({tag, ".imem"},  imem_addr, p);
    endtask

    task automatic do_reset();
        rst = 1'b1; hazard = 1'b0; br_taken = 1'b0; br_addr = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hazard = 1'b0; br_taken = 1'b0; br_addr = '0;
        #2;
        do_reset();

        // Reset state
        chk_ifid("rst", 32'h0, 32'h0, 1'b0, 32'h0);
        chk("rst.stall", 32'(stall_cnt), 32'd0);
        chk("rst.flush", 32'(flush_cnt), 32'd0);

        // Free-run three cycles
        step(); chk_ifid("adv1", 32'h1000_0000, 32'd4,  1'b1, 32'd4);
        step(); chk_ifid("adv2", 32'h1000_0004, 32'd8,  1'b1, 32'd8);
        step(); chk_ifid("adv3", 32'h1000_0008, 32'd12, 1'b1, 32'd12);

        // Fresh start, two advances, then freeze at PC=8 for two cycles
        do_reset();
        step(); step();
        hazard = 1'b1;
        step(); chk_ifid("frz1", 32'h1000_0004, 32'd8, 1'b1, 32'd8);
        chk("frz1.stall", 32'(stall_cnt), 32'd1);
        step(); chk_ifid("frz2", 32'h1000_0004, 32'd8, 1'b1, 32'd8);
        chk("frz2.stall", 32'(stall_cnt), 32'd2);
        hazard = 1'b0;
        step(); chk_ifid("resume", 32'h1000_0008, 32'd12, 1'b1, 32'd12);
        chk("resume.stall", 32'(stall_cnt), 32'd2);

        // Branch with simultaneous hazard; low address bits ignored
        br_taken = 1'b1; br_addr = 32'h0000_0043; hazard = 1'b1;
        step(); chk_ifid("br", 32'h0, 32'h0, 1'b0, 32'h40);
        chk("br.flush", 32'(flush_cnt), 32'd1);
        chk("br.stall", 32'(stall_cnt), 32'd2);
        br_taken = 1'b0; hazard = 1'b0;
        step(); chk_ifid("br.tgt", 32'h1000_0040, 32'h44, 1'b1, 32'h44);

        // PC wrap through redirect to the top word
        br_taken = 1'b1; br_addr = 32'hFFFF_FFFC;
        step(); chk_ifid("wrap.br", 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC);
        chk("wrap.flush", 32'(flush_cnt), 32'd2);
        br_taken = 1'b0;
        step(); chk_ifid("wrap.adv", 32'h0FFF_FFFC, 32'h0, 1'b1, 32'h0);

        // Freeze over a bubble: redirect then freeze still counts
        br_taken = 1'b1; br_addr = 32'h0000_0100;
        step();
        br_taken = 1'b0; hazard = 1'b1;
        step(); chk_ifid("bubfrz", 32'h0, 32'h0, 1'b0, 32'h100);
        chk("bubfrz.stall", 32'(stall_cnt), 32'd3);

        // Stall counter saturation: 20 hazard cycles total from here
        for (int i = 1; i < 20; i++) begin
            step();
            chk($sformatf("sat.stall%0d", i), 32'(stall_cnt), (3 + i > 15) ? 32'd15 : 32'(3 + i));
        end
        chk_ifid("sat.hold", 32'h0, 32'h0, 1'b0, 32'h100);
        hazard = 1'b0;

        // Flush counter saturation: 15 more redirects from 3
        for (int i = 1; i <= 15; i++) begin
            br_taken = 1'b1; br_addr = 32'(i * 16);
            step();
        end
        chk("sat.flush", 32'(flush_cnt), 32'd15);
        chk("sat.flushpc", pc, 32'd240);

        // Reset in the same cycle as a taken branch
        br_taken = 1'b1; br_addr = 32'h0000_0080; rst = 1'b1;
        step();
        rst = 1'b0; br_taken = 1'b0;
        chk_ifid("rstbr", 32'h0, 32'h0, 1'b0, 32'h0);
        chk("rstbr.stall", 32'(stall_cnt), 32'd0);
        chk("rstbr.flush", 32'(flush_cnt), 32'd0);
        step(); chk_ifid("rstbr.adv", 32'h1000_0000, 32'd4, 1'b1, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage_unit.md
# if_stage_unit

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage pipeline. Holds the program counter, drives the instruction-memory address, and captures the fetched instruction into the IF/ID register. It sits directly upstream of the decode stage and consumes the hazard unit's `Hazard_detected_signal` to freeze fetch. It also consumes the branch resolution from EXE to redirect and flush. It keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- `ADDR_W`, 32 — PC / instruction-address width.
- `RESET_PC`, 0 — PC value after reset; bits [1:0] must be 0.
- `CNT_W`, 16 — width of the stall and flush counters.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `Hazard_detected_signal`  in  1  — freeze request from the hazard unit.
- `Br_taken`  in  1  — branch/jump resolved taken in EXE this cycle.
- `Br_addr`  in  ADDR_W  — branch target byte address.
- `imem_addr`  out  ADDR_W  — instruction-memory address; combinationally equal to the current PC.
- `imem_rdata`  in  32  — instruction word; combinational read, valid the same cycle as `imem_addr`.
- `PC`  out  ADDR_W  — current fetch PC.
- `IF_ID_PC`  out  ADDR_W  — registered PC+4 of the held instruction.
- `IF_ID_Instruction`  out  32  — registered instruction.
- `IF_ID_valid`  out  1  — the IF/ID register holds a real instruction; 0 = bubble.
- `stall_cnt`  out  CNT_W  — cycles frozen by hazard.
- `flush_cnt`  out  CNT_W  — taken-branch redirects.

## Operation
- Reset (`rst`=1 at edge):
  - `PC`=`RESET_PC`.
  - `IF_ID_PC`=0, `IF_ID_Instruction`=0, `IF_ID_valid`=0.
  - `stall_cnt`=0, `flush_cnt`=0.
  - Reset overrides every other input.
- Each edge, exactly one of three modes applies, in priority order:
  1. **REDIRECT** (`Br_taken`=1), regardless of hazard:
     - `PC` ← {`Br_addr`[ADDR_W-1:2], 2'b00}.
     - IF/ID ← flushed: `IF_ID_Instruction`=0, `IF_ID_PC`=0, `IF_ID_valid`=0.
     - `flush_cnt`++.
  2. **FREEZE** (`Hazard_detected_signal`=1, `Br_taken`=0):
     - `PC` and the whole IF/ID register hold.
     - `stall_cnt`++.
  3. **ADVANCE** (otherwise):
     - `PC` ← `PC`+4.
     - `IF_ID_PC` ← `PC`+4.
     - `IF_ID_Instruction` ← `imem_rdata`.
     - `IF_ID_valid` ← 1.
- Arithmetic:
  - `PC`+4 is modulo 2^ADDR_W; 0xFFFF_FFFC+4 wraps to 0 with no error.
  - `Br_addr` bits [1:0] are ignored.
- Counters:
  - Unsigned, saturating at 2^CNT_W−1; no wrap.
  - Cleared only by `rst`.
- A freeze while `IF_ID_valid`=0 still holds state and still counts a stall.
- The hazard signal does not insert the ID/EXE bubble; the decode stage handles that.

## Timing
- `imem_addr` tracks `PC` with zero latency (combinational).
- Fetch-to-IF/ID latency: 1 cycle.
  - Instruction at `PC`=A appears on `IF_ID_Instruction` the cycle after the ADVANCE edge, with `IF_ID_PC`=A+4.
- Redirect penalty:
  - The edge with `Br_taken`=1 yields a bubble in IF/ID.
  - The target instruction appears in IF/ID one ADVANCE edge later.
- Freeze of N consecutive cycles:
  - Outputs are stable for N cycles.
  - `stall_cnt` rises by N.
  - The first ADVANCE afterwards resumes from the held `PC`.
- Reset asserted mid-freeze or mid-redirect: the next edge yields reset values; the pending branch is discarded.
- First cycle after reset release: `PC`=`RESET_PC`, `IF_ID_valid`=0.

## Test plan
- **Reset then free-run:** `RESET_PC`=0, memory word at addr k = 0x1000_0000+k; 3 ADVANCE cycles.
  - Required: IF/ID shows (instr 0x1000_0000, PC 4), then (0x1000_0004, 8), then (0x1000_0008, 12); `PC`=12.
- **Hazard freeze:** assert `Hazard_detected_signal` for 2 cycles at `PC`=8.
  - Required: `PC` stays 8 and IF/ID holds (0x1000_0004, 8) for 2 cycles; `stall_cnt`=2.
  - Next ADVANCE: IF/ID=(0x1000_0008, 12).
- **Branch with simultaneous hazard:** `Br_taken`=1, `Br_addr`=0x43, hazard=1 in the same cycle.
  - Required: `PC`=0x40, `IF_ID_valid`=0, `IF_ID_Instruction`=0; `flush_cnt`=1, `stall_cnt` unchanged.
  - Next ADVANCE: `IF_ID_PC`=0x44.
- **PC wrap:** `ADDR_W`=32, redirect to 0xFFFF_FFFC, then ADVANCE.
  - Required: `PC`=0; `IF_ID_PC`=0.
- **Counter saturation:** `CNT_W`=4, hold hazard 20 cycles.
  - Required: `stall_cnt` stops at 15.
- **Reset mid-operation:** assert `rst` in the same cycle as `Br_taken`=1.
  - Required: next cycle `PC`=`RESET_PC`; all IF/ID outputs and both counters are 0.
